// File: rtl/vx_stream_rr_arbiter_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
// State encoding and index-width helper used by all arbiter files.
package vx_stream_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        HOLD   = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_stream_rr_arbiter_if.sv
// Request/response bundle between N requesters and one output stream.
// master drives requests and downstream ready; slave is the arbiter.
interface vx_stream_rr_arbiter_if
    import vx_stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int DATAW        = 32,
    parameter int LOG_NUM_REQS = log2up(NUM_REQS)
);
    logic [NUM_REQS-1:0]       valid_in;
    logic [NUM_REQS*DATAW-1:0] data_in;
    logic [NUM_REQS-1:0]       last_in;
    logic [NUM_REQS-1:0]       ready_in;
    logic                      valid_out;
    logic [DATAW-1:0]          data_out;
    logic                      last_out;
    logic [LOG_NUM_REQS-1:0]   sel_out;
    logic                      ready_out;

    modport master (
        output valid_in, data_in, last_in, ready_out,
        input  ready_in, valid_out, data_out, last_out, sel_out
    );

    modport slave (
        input  valid_in, data_in, last_in, ready_out,
        output ready_in, valid_out, data_out, last_out, sel_out
    );
endinterface

// File: rtl/vx_priority_encoder.sv
// Priority encoder: index of lowest set bit (or highest when REVERSE=1).
// valid_out flags that at least one bit is set.
module vx_priority_encoder
    import vx_stream_rr_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int REVERSE = 0,
    parameter int LOGN    = log2up(N)
) (
    input  logic [N-1:0]    data_in,
    output logic [LOGN-1:0] index,
    output logic            valid_out
);
    assign valid_out = |data_in;

    // later hits overwrite earlier ones, so scan from the losing end
    always_comb begin
        index = '0;
        if (REVERSE == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (data_in[i]) index = LOGN'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (data_in[i]) index = LOGN'(i);
            end
        end
    end
endmodule

// File: rtl/vx_rr_mask_gen.sv
// Round-robin mask: marks every requester strictly above the last winner.
// Empty when the pointer sits on the top index, so callers wrap around.
module vx_rr_mask_gen
    import vx_stream_rr_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int LOGN = log2up(N)
) (
    input  logic [LOGN-1:0] ptr,
    output logic [N-1:0]    mask
);
    // one compare per requester against the pointer
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (LOGN'(i) > ptr);
        end
    end
endmodule

// File: rtl/vx_stream_rr_arbiter.sv
// Round-robin stream arbiter with optional packet lock.
// A stalled or mid-packet grant is pinned until its beat/packet ends.
module vx_stream_rr_arbiter
    import vx_stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int DATAW        = 32,
    parameter int LOCK_PACKET  = 1,
    parameter int LOG_NUM_REQS = log2up(NUM_REQS)
) (
    input logic clk,
    input logic reset_n,
    vx_stream_rr_arbiter_if.slave bus
);
    localparam int L = LOG_NUM_REQS;

    arb_state_t          state_r, state_n;
    logic [L-1:0]        ptr_r, ptr_n;
    logic [L-1:0]        lock_idx_r, lock_idx_n;
    logic [NUM_REQS-1:0] mask, req_masked;
    logic [L-1:0]        idx_masked, idx_raw, sel_arb, g;
    logic                has_masked, has_raw;
    logic                vo, fire, end_pkt;

    vx_rr_mask_gen #(
        .N    (NUM_REQS),
        .LOGN (L)
    ) u_mask (
        .ptr  (ptr_r),
        .mask (mask)
    );

    assign req_masked = bus.valid_in & mask;

    vx_priority_encoder #(
        .N       (NUM_REQS),
        .REVERSE (0),
        .LOGN    (L)
    ) u_enc_masked (
        .data_in   (req_masked),
        .index     (idx_masked),
        .valid_out (has_masked)
    );

    vx_priority_encoder #(
        .N       (NUM_REQS),
        .REVERSE (0),
        .LOGN    (L)
    ) u_enc_raw (
        .data_in   (bus.valid_in),
        .index     (idx_raw),
        .valid_out (has_raw)
    );

    assign sel_arb = has_masked ? idx_masked : idx_raw;
    assign g       = (state_r == ARB) ? sel_arb : lock_idx_r;

    assign vo = reset_n & ((state_r == ARB) ? has_raw
                                            : bus.valid_in[lock_idx_r]);
    assign fire    = vo & bus.ready_out;
    assign end_pkt = fire & (bus.last_in[g] | (LOCK_PACKET == 0));

    assign bus.valid_out = vo;
    assign bus.data_out  = bus.data_in[g*DATAW +: DATAW];
    assign bus.last_out  = bus.last_in[g];
    assign bus.sel_out   = reset_n ? g : '0;

    // one-hot ready back to the granted requester only on a real beat
    always_comb begin
        bus.ready_in = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            bus.ready_in[i] = (g == L'(i)) & fire;
        end
    end

    // next state: pin grant on stall or open packet, advance ptr on end
    always_comb begin
        state_n    = state_r;
        ptr_n      = ptr_r;
        lock_idx_n = lock_idx_r;
        unique case (state_r)
            ARB: begin
                if (end_pkt) begin
                    ptr_n = g;
                end else if (fire) begin
                    state_n    = LOCKED;
                    lock_idx_n = g;
                end else if (vo) begin
                    state_n    = HOLD;
                    lock_idx_n = g;
                end
            end
            HOLD: begin
                if (end_pkt) begin
                    state_n = ARB;
                    ptr_n   = lock_idx_r;
                end else if (fire) begin
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (end_pkt) begin
                    state_n = ARB;
                    ptr_n   = lock_idx_r;
                end
            end
            default: state_n = ARB;
        endcase
    end

    // state registers; reset drops any lock and favours requester 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ARB;
            ptr_r      <= L'(NUM_REQS - 1);
            lock_idx_r <= '0;
        end else begin
            state_r    <= state_n;
            ptr_r      <= ptr_n;
            lock_idx_r <= lock_idx_n;
        end
    end

    // a pinned requester must keep valid until its beat/packet ends
    a_pinned_valid: assert property (
        @(posedge clk) disable iff (!reset_n)
        (state_r != ARB) |-> bus.valid_in[lock_idx_r]
    ) else $warning("arbiter: pinned requester dropped valid");

endmodule

// File: tb/tb_vx_stream_rr_arbiter.sv
// Testbench for vx_stream_rr_arbiter: a packet-lock and a no-lock instance
// share stimulus; a circular-search reference model predicts each cycle.
module tb_vx_stream_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   v = '0;
    logic [127:0] d = '0;
    logic [3:0]   l = '0;
    logic         r = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vx_stream_rr_arbiter_if #(.NUM_REQS(4), .DATAW(32)) bus_lk ();
    vx_stream_rr_arbiter_if #(.NUM_REQS(4), .DATAW(32)) bus_nl ();

    assign bus_lk.valid_in  = v;
    assign bus_lk.data_in   = d;
    assign bus_lk.last_in   = l;
    assign bus_lk.ready_out = r;
    assign bus_nl.valid_in  = v;
    assign bus_nl.data_in   = d;
    assign bus_nl.last_in   = l;
    assign bus_nl.ready_out = r;

    vx_stream_rr_arbiter #(
        .NUM_REQS(4), .DATAW(32), .LOCK_PACKET(1)
    ) dut_lk (
        .clk(clk), .reset_n(rst_n), .bus(bus_lk)
    );

    vx_stream_rr_arbiter #(
        .NUM_REQS(4), .DATAW(32), .LOCK_PACKET(0)
    ) dut_nl (
        .clk(clk), .reset_n(rst_n), .bus(bus_nl)
    );

    // index 0 = packet-lock instance, 1 = no-lock instance
    logic        o_vo   [2];
    logic [3:0]  o_rdy  [2];
    logic [31:0] o_data [2];
    logic        o_last [2];
    logic [1:0]  o_sel  [2];

    assign o_vo[0]   = bus_lk.valid_out;
    assign o_rdy[0]  = bus_lk.ready_in;
    assign o_data[0] = bus_lk.data_out;
    assign o_last[0] = bus_lk.last_out;
    assign o_sel[0]  = bus_lk.sel_out;
    assign o_vo[1]   = bus_nl.valid_out;
    assign o_rdy[1]  = bus_nl.ready_in;
    assign o_data[1] = bus_nl.data_out;
    assign o_last[1] = bus_nl.last_out;
    assign o_sel[1]  = bus_nl.sel_out;

    // model: last winner plus an owner that holds the output (-1 = free)
    int m_last  [2];
    int m_owner [2];
    bit e_vo    [2];
    int e_g     [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            e_vo[k] = 1'b0;
            e_g[k]  = 0;
            if (m_owner[k] >= 0) begin
                e_g[k]  = m_owner[k];
                e_vo[k] = v[m_owner[k]];
            end else begin
                for (int s = 1; s <= 4; s++) begin
                    if (!e_vo[k] && v[(m_last[k] + s) % 4]) begin
                        e_vo[k] = 1'b1;
                        e_g[k]  = (m_last[k] + s) % 4;
                    end
                end
            end
            e_vo[k] = e_vo[k] & rst_n;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_last[k]  <= 3;
                m_owner[k] <= -1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (e_vo[k] && r && (l[e_g[k]] || k == 1)) begin
                    m_owner[k] <= -1;
                    m_last[k]  <= e_g[k];
                end else if (e_vo[k]) begin
                    m_owner[k] <= e_g[k];
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        v = '0; l = '0; r = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int exp_sel;
        rst_n = 1'b0;
        v = 4'b1111; l = 4'b1111; r = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_vo[k] !== 1'b0 || o_rdy[k] !== 4'b0 || o_sel[k] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_hold dut%0d got vo=%b rdy=%b sel=%0d exp 0,0000,0",
                         k, o_vo[k], o_rdy[k], o_sel[k]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_sel = i % 4;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_vo[k] !== 1'b1 || o_sel[k] !== 2'(exp_sel)) begin
                    n_fail++;
                    $display("FAIL reset_seq dut%0d beat%0d got vo=%b sel=%0d exp 1,%0d",
                             k, i, o_vo[k], o_sel[k], exp_sel);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        do_reset();
        v = 4'b0110; l = 4'b1111; r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_vo[k] !== 1'b1 || o_sel[k] !== 2'd1 || o_rdy[k] !== 4'b0) begin
                    n_fail++;
                    $display("FAIL stall dut%0d cyc%0d got vo=%b sel=%0d rdy=%b exp 1,1,0000",
                             k, i, o_vo[k], o_sel[k], o_rdy[k]);
                end
            end
            @(posedge clk); #1;
        end
        r = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_sel[k] !== 2'(i + 1) || o_rdy[k] !== 4'(1 << (i + 1))) begin
                    n_fail++;
                    $display("FAIL stall_release dut%0d beat%0d got sel=%0d rdy=%b exp %0d",
                             k, i, o_sel[k], o_rdy[k], i + 1);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_packet_lock();
        int exp_lk [4] = '{0, 0, 0, 1};
        int exp_nl [4] = '{0, 1, 0, 1};
        do_reset();
        v = 4'b0011; r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            l = {3'b001, (i == 2)};
            @(negedge clk);
            n_checks++;
            if (o_sel[0] !== 2'(exp_lk[i])) begin
                n_fail++;
                $display("FAIL packet_lock beat%0d got sel=%0d exp %0d",
                         i, o_sel[0], exp_lk[i]);
            end
            n_checks++;
            if (o_sel[1] !== 2'(exp_nl[i])) begin
                n_fail++;
                $display("FAIL no_lock beat%0d got sel=%0d exp %0d",
                         i, o_sel[1], exp_nl[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap_sparse();
        int exp_sel [3] = '{0, 3, 0};
        do_reset();
        v = 4'b1001; l = 4'b1111; r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_sel[k] !== 2'(exp_sel[i]) || o_vo[k] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap dut%0d beat%0d got sel=%0d vo=%b exp %0d",
                             k, i, o_sel[k], o_vo[k], exp_sel[i]);
                end
            end
            @(posedge clk); #1;
        end
        v = 4'b0100; l = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            l[2] = (i == 4);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_sel[k] !== 2'd2 || o_rdy[k] !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL lone_stream dut%0d beat%0d got sel=%0d rdy=%b exp 2,0100",
                             k, i, o_sel[k], o_rdy[k]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        v = 4'b1000; l = 4'b0000; r = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_sel[0] !== 2'd3 || o_vo[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midpkt_beat1 got sel=%0d vo=%b exp 3,1", o_sel[0], o_vo[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_vo[0] !== 1'b0 || o_sel[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL midpkt_reset got vo=%b sel=%0d exp 0,0", o_vo[0], o_sel[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        v = 4'b1001;
        @(negedge clk);
        n_checks++;
        if (o_sel[0] !== 2'd0 || o_vo[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midpkt_release got sel=%0d vo=%b exp 0,1", o_sel[0], o_vo[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_valid_drop();
        do_reset();
        v = 4'b0001; l = 4'b0000; r = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        v = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (o_vo[0] !== 1'b0 || o_rdy[0] !== 4'b0) begin
            n_fail++;
            $display("FAIL valid_drop got vo=%b rdy=%b exp 0,0000", o_vo[0], o_rdy[0]);
        end
        @(posedge clk); #1;
        v = 4'b0011; l = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (o_sel[0] !== 2'd0 || o_vo[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_kept got sel=%0d vo=%b exp 0,1", o_sel[0], o_vo[0]);
        end
        @(posedge clk); #1;
        v = 4'b0011; l = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (o_sel[0] !== 2'd1) begin
            n_fail++;
            $display("FAIL drop_after got sel=%0d exp 1", o_sel[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [3:0]  er;
        logic [31:0] ed;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v = 4'($urandom_range(0, 15));
            l = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 3) != 0);
            d = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 2; k++) begin
                if (m_owner[k] >= 0) v[m_owner[k]] = 1'b1;
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                er = (e_vo[k] && r) ? 4'(1 << e_g[k]) : 4'b0;
                n_checks++;
                if (o_vo[k] !== e_vo[k] || o_rdy[k] !== er) begin
                    n_fail++;
                    $display("FAIL rand_hs dut%0d cyc%0d got vo=%b rdy=%b exp %b,%b",
                             k, c, o_vo[k], o_rdy[k], e_vo[k], er);
                end
                if (e_vo[k]) begin
                    ed = d[e_g[k]*32 +: 32];
                    n_checks++;
                    if (o_sel[k] !== 2'(e_g[k]) || o_data[k] !== ed
                        || o_last[k] !== l[e_g[k]]) begin
                        n_fail++;
                        $display("FAIL rand_sel dut%0d cyc%0d got sel=%0d data=%h exp %0d,%h",
                                 k, c, o_sel[k], o_data[k], e_g[k], ed);
                    end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_stall();
        test_packet_lock();
        test_wrap_sparse();
        test_reset_mid_packet();
        test_valid_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
